// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_BLK = 4;

    typedef struct packed {
        logic g;
        logic p;
    } cla_gp_t;

    function automatic int unsigned cla_nblk(input int unsigned width);
        return width / CLA_BLK;
    endfunction

    // Legal operand widths: whole 4-bit blocks, 4..64 bits.
    function automatic bit cla_width_ok(input int unsigned width);
        return ((width % CLA_BLK) == 0) && (width >= 4) && (width <= 64);
    endfunction

endpackage

// File: rtl/cla_lookahead4.sv
// 4-bit lookahead carry unit: bit carries plus group generate/propagate.
module cla_lookahead4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [4:1] c_c,
    output logic       g_grp_c,
    output logic       p_grp_c
);

    assign c_c[1] = g[0] | (p[0] & cin);
    assign c_c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c_c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                  | (p[2] & p[1] & p[0] & cin);
    assign c_c[4] = g_grp_c | (p_grp_c & cin);

    assign g_grp_c = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                   | (p[3] & p[2] & p[1] & g[0]);
    assign p_grp_c = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output out_ovf.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef CLA_PIPE_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_cout
);

    localparam int unsigned NBLK = cla_nblk(WIDTH);

    if (!cla_width_ok(WIDTH)) begin : g_width_chk
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 in 4..64");
    end

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_p;
    logic [WIDTH-1:0]      s1_g;
    cla_gp_t [NBLK-1:0]    s1_grp;
    logic                  s1_c0;

    logic                  s2_load_c;
    logic                  s1_load_c;

    // Stage 2 takes a beat when empty or draining; stage 1 advances with it.
    assign s2_load_c = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load_c;
    assign s1_load_c = in_valid && in_ready;

    logic [WIDTH-1:0]      b_mod_c;
    logic [WIDTH-1:0]      p_c;
    logic [WIDTH-1:0]      g_c;
    logic                  c0_c;
    cla_gp_t [NBLK-1:0]    grp_c;

    assign b_mod_c = in_sub ? ~in_b : in_b;
    assign c0_c    = in_sub | in_cin;
    assign p_c     = in_a ^ b_mod_c;
    assign g_c     = in_a & b_mod_c;

    // First level: per-block group generate/propagate.
    for (genvar k = 0; k < NBLK; k++) begin : g_s1_blk
        logic [4:1] unused_c;
        cla_lookahead4 u_la (
            .g       (g_c[CLA_BLK*k +: CLA_BLK]),
            .p       (p_c[CLA_BLK*k +: CLA_BLK]),
            .cin     (1'b0),
            .c_c     (unused_c),
            .g_grp_c (grp_c[k].g),
            .p_grp_c (grp_c[k].p)
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_grp   <= '0;
            s1_c0    <= 1'b0;
        end else begin
            if (s1_load_c) begin
                s1_p   <= p_c;
                s1_g   <= g_c;
                s1_grp <= grp_c;
                s1_c0  <= c0_c;
            end
            if (s1_load_c) begin
                s1_valid <= 1'b1;
            end else if (s2_load_c) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Second level: each block carry as a flat sum of products of G/P and c0.
    logic [NBLK:0] blk_c_c;

    always_comb begin
        logic acc;
        logic term;
        acc        = 1'b0;
        term       = 1'b0;
        blk_c_c    = '0;
        blk_c_c[0] = s1_c0;
        for (int k = 0; k < int'(NBLK); k++) begin
            acc = s1_c0;
            for (int m = 0; m <= k; m++) begin
                acc = acc & s1_grp[m].p;
            end
            for (int j = 0; j <= k; j++) begin
                term = s1_grp[j].g;
                for (int m = j + 1; m <= k; m++) begin
                    term = term & s1_grp[m].p;
                end
                acc = acc | term;
            end
            blk_c_c[k+1] = acc;
        end
    end

    logic [WIDTH:0]   carry_c;
    logic [WIDTH-1:0] sum_c;

    assign carry_c[WIDTH] = blk_c_c[NBLK];

    for (genvar k = 0; k < NBLK; k++) begin : g_s2_blk
        logic [4:1] blk_bit_c;
        logic       unused_c4;
        logic       unused_g;
        logic       unused_p;
        cla_lookahead4 u_la (
            .g       (s1_g[CLA_BLK*k +: CLA_BLK]),
            .p       (s1_p[CLA_BLK*k +: CLA_BLK]),
            .cin     (blk_c_c[k]),
            .c_c     (blk_bit_c),
            .g_grp_c (unused_g),
            .p_grp_c (unused_p)
        );
        assign carry_c[CLA_BLK*k]          = blk_c_c[k];
        assign carry_c[CLA_BLK*k + 1 +: 3] = blk_bit_c[3:1];
        assign unused_c4                   = blk_bit_c[4];
    end

    assign sum_c = s1_p ^ carry_c[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef CLA_PIPE_OVF_EN
            out_ovf   <= 1'b0;
`endif
        end else if (s2_load_c) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sum  <= sum_c;
                out_cout <= carry_c[WIDTH];
`ifdef CLA_PIPE_OVF_EN
                out_ovf  <= carry_c[WIDTH-1] ^ carry_c[WIDTH];
`endif
            end
        end
    end

endmodule
